// File: rtl/iic_slave_ctrl_if.sv
// Register-file side of the I2C target: pointer, write strobe/data, read request/data, status.
interface iic_slave_ctrl_if;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        busy;
  logic        ack_err;

  modport master (
    output reg_addr, wr_data, wr_en, rd_req, busy, ack_err,
    input  rd_data
  );

  modport slave (
    input  reg_addr, wr_data, wr_en, rd_req, busy, ack_err,
    output rd_data
  );
endinterface

// File: rtl/iic_slave_ctrl.sv
// I2C target endpoint: oversamples SCL/SDA, decodes address/sub-address, drives a register file.
// Never stretches SCL; SDA is open-drain and only changes on synchronised SCL falling edges.
module iic_slave_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter bit         ADDR16   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iic_clk,
  inout  wire              iic_sda,
  iic_slave_ctrl_if.master rf
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_SUB_ADDR, S_SUB_ACK, S_WR_DATA,
    S_WR_ACK, S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  // [0] first sync stage, [1] synchronised value, [2] history for edge detection
  logic [2:0] scl_sr, sda_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], iic_clk};
      sda_sr <= {sda_sr[1:0], iic_sda};
    end
  end

  logic scl_rise, scl_fall, sda_now, bus_start, bus_stop;
  assign scl_rise  =  scl_sr[1] & ~scl_sr[2];
  assign scl_fall  = ~scl_sr[1] &  scl_sr[2];
  assign sda_now   =  sda_sr[1];
  assign bus_start =  scl_sr[1] & scl_sr[2] & ~sda_sr[1] &  sda_sr[2];
  assign bus_stop  =  scl_sr[1] & scl_sr[2] &  sda_sr[1] & ~sda_sr[2];

  function automatic logic [15:0] next_addr(input logic [15:0] a);
    if (ADDR16) return a + 16'd1;
    else        return {8'h00, a[7:0] + 8'd1};
  endfunction

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  hi_byte;
  logic        sub_lo;
  logic        rw;
  logic [1:0]  rd_step;
  logic        inc_pend;
  logic        nack_pend;
  logic        sda_oe;
  logic [15:0] reg_addr_q;
  logic [7:0]  wr_data_q;
  logic        wr_en_q, rd_req_q, busy_q, ack_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      hi_byte    <= 8'h00;
      sub_lo     <= 1'b0;
      rw         <= 1'b0;
      rd_step    <= 2'd0;
      inc_pend   <= 1'b0;
      nack_pend  <= 1'b0;
      sda_oe     <= 1'b0;
      reg_addr_q <= 16'h0000;
      wr_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      ack_err_q <= 1'b0;
      if (inc_pend) begin
        reg_addr_q <= next_addr(reg_addr_q);
        inc_pend   <= 1'b0;
      end

      if (bus_stop) begin
        state     <= S_IDLE;
        sda_oe    <= 1'b0;
        busy_q    <= 1'b0;
        nack_pend <= 1'b0;
        bit_cnt   <= 4'd0;
      end else if (bus_start) begin
        // A START after a NACK with no STOP in between means the read was cut short
        state     <= S_DEV_ADDR;
        sda_oe    <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt   <= 4'd0;
        ack_err_q <= nack_pend;
        nack_pend <= 1'b0;
      end else begin
        case (state)
          S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_now};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == S_DEV_ADDR) begin
                if (shift[7:1] == DEV_ADDR) begin
                  sda_oe <= 1'b1;
                  busy_q <= 1'b1;
                  rw     <= shift[0];
                  sub_lo <= 1'b0;
                  state  <= S_DEV_ACK;
                end else begin
                  state  <= S_IGNORE;
                end
              end else if (state == S_SUB_ADDR) begin
                sda_oe <= 1'b1;
                state  <= S_SUB_ACK;
                if (ADDR16 && !sub_lo) hi_byte    <= shift;
                else if (ADDR16)       reg_addr_q <= {hi_byte, shift};
                else                   reg_addr_q <= {8'h00, shift};
              end else begin
                sda_oe    <= 1'b1;
                wr_data_q <= shift;
                wr_en_q   <= 1'b1;
                inc_pend  <= 1'b1;
                state     <= S_WR_ACK;
              end
            end
          end
          S_DEV_ACK: begin
            // Reads fetch the first byte while the address ACK is still on the bus
            if (rw) begin
              state   <= S_RD_LOAD;
              rd_step <= 2'd0;
            end else if (scl_fall) begin
              sda_oe  <= 1'b0;
              state   <= S_SUB_ADDR;
            end
          end
          S_SUB_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              if (ADDR16 && !sub_lo) begin
                sub_lo <= 1'b1;
                state  <= S_SUB_ADDR;
              end else begin
                state  <= S_WR_DATA;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= S_WR_DATA;
            end
          end
          S_RD_LOAD: begin
            case (rd_step)
              2'd0: begin
                rd_req_q <= 1'b1;
                rd_step  <= 2'd1;
              end
              2'd1: begin
                shift   <= rf.rd_data;
                rd_step <= 2'd2;
              end
              default: begin
                if (scl_fall) begin
                  sda_oe  <= ~shift[7];
                  shift   <= {shift[6:0], 1'b0};
                  bit_cnt <= 4'd1;
                  state   <= S_RD_DATA;
                end
              end
            endcase
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_RD_ACK;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_now) begin
                reg_addr_q <= next_addr(reg_addr_q);
                rd_step    <= 2'd0;
                state      <= S_RD_LOAD;
              end else begin
                sda_oe    <= 1'b0;
                nack_pend <= 1'b1;
                state     <= S_IGNORE;
              end
            end
          end
          S_IDLE, S_IGNORE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign iic_sda     = sda_oe ? 1'b0 : 1'bz;
  assign rf.reg_addr = reg_addr_q;
  assign rf.wr_data  = wr_data_q;
  assign rf.wr_en    = wr_en_q;
  assign rf.rd_req   = rd_req_q;
  assign rf.busy     = busy_q;
  assign rf.ack_err  = ack_err_q;

endmodule

// File: tb/tb_iic_slave_ctrl.sv
// Bench for iic_slave_ctrl: bit-banged I2C master, register-file scoreboard, two targets on one bus.
module tb_iic_slave_ctrl;

  localparam time Q = 50ns;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  iic_sda;

  always #5 clk = ~clk;

  assign iic_sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (iic_sda);

  iic_slave_ctrl_if rf1 ();
  iic_slave_ctrl_if rf2 ();

  iic_slave_ctrl #(.DEV_ADDR(7'h50), .ADDR16(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .iic_clk(m_scl), .iic_sda(iic_sda), .rf(rf1));
  iic_slave_ctrl #(.DEV_ADDR(7'h52), .ADDR16(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .iic_clk(m_scl), .iic_sda(iic_sda), .rf(rf2));

  // Register model: each location reads back as its low address byte plus one
  logic [7:0] rd_data1;
  always_ff @(posedge clk) rd_data1 <= rf1.reg_addr[7:0] + 8'd1;
  assign rf1.rd_data = rd_data1;
  assign rf2.rd_data = 8'h00;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_wr1[$];
  wr_t         exp_wr2[$];
  logic [15:0] exp_rd1[$];

  int n_checks = 0;
  int n_fail = 0;
  int dut_low_cnt = 0;
  int busy_cyc = 0;
  int ack_err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [15:0] a);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected strobe at addr %0h, required none", name, a);
  endtask

  task automatic bus_start();
    if (!m_scl) begin
      m_sda_low = 1'b0; #Q;
      m_scl = 1'b1;     #Q;
    end
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b1;     #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; #Q;
    m_scl = 1'b1;   #(2*Q);
    m_scl = 1'b0;   #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1;     #Q;
    b = iic_sda;      #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~mack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         low0, busy0;

    // Scoreboard monitor: pops expectations whenever a DUT strobes the register file
    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (!m_sda_low && iic_sda == 1'b0) dut_low_cnt++;
        if (rf1.busy || rf2.busy) busy_cyc++;
        if (rf1.ack_err) ack_err_cnt++;
        if (rf1.wr_en) begin
          chk("wr1_busy", rf1.busy, 1);
          chk("wr1_rd_excl", rf1.rd_req, 0);
          if (exp_wr1.size() == 0) unexpected("wr1_unexpected", rf1.reg_addr);
          else begin
            e = exp_wr1.pop_front();
            chk("wr1_addr", rf1.reg_addr, e.a);
            chk("wr1_data", rf1.wr_data, e.d);
          end
        end
        if (rf1.rd_req) begin
          chk("rd1_busy", rf1.busy, 1);
          if (exp_rd1.size() == 0) unexpected("rd1_unexpected", rf1.reg_addr);
          else chk("rd1_addr", rf1.reg_addr, exp_rd1.pop_front());
        end
        if (rf2.wr_en) begin
          if (exp_wr2.size() == 0) unexpected("wr2_unexpected", rf2.reg_addr);
          else begin
            e = exp_wr2.pop_front();
            chk("wr2_addr", rf2.reg_addr, e.a);
            chk("wr2_data", rf2.wr_data, e.d);
          end
        end
        if (rf2.rd_req) unexpected("rd2_unexpected", rf2.reg_addr);
      end
    join_none

    #100 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_reg_addr", rf1.reg_addr, 16'h0000);
    chk("rst_wr_data", rf1.wr_data, 8'h00);
    chk("rst_busy", rf1.busy, 0);
    chk("rst_ack_err", rf1.ack_err, 0);
    chk("rst_sda", iic_sda, 1);

    // Single write, 8-bit sub-address
    exp_wr1.push_back('{16'h0012, 8'h5A});
    bus_start();
    write_byte(8'hA0, ack); chk("w1_dev_ack", ack, 1);
    chk("w1_busy", rf1.busy, 1);
    write_byte(8'h12, ack); chk("w1_sub_ack", ack, 1);
    write_byte(8'h5A, ack); chk("w1_data_ack", ack, 1);
    bus_stop();
    #(4*Q);
    chk("w1_reg_addr", rf1.reg_addr, 16'h0013);
    chk("w1_busy_after_p", rf1.busy, 0);

    // Random read via repeated START, sequential bytes
    bus_start();
    write_byte(8'hA0, ack); chk("rr_dev_ack", ack, 1);
    write_byte(8'h34, ack); chk("rr_sub_ack", ack, 1);
    exp_rd1.push_back(16'h0034);
    exp_rd1.push_back(16'h0035);
    exp_rd1.push_back(16'h0036);
    bus_start();
    write_byte(8'hA1, ack); chk("rr_rd_ack", ack, 1);
    read_byte(rb, 1'b1); chk("rr_byte0", rb, 8'h35);
    read_byte(rb, 1'b1); chk("rr_byte1", rb, 8'h36);
    read_byte(rb, 1'b0); chk("rr_byte2", rb, 8'h37);
    chk("rr_sda_after_nack", iic_sda, 1);
    bus_stop();
    #(4*Q);
    chk("rr_ack_err", ack_err_cnt, 0);
    chk("rr_reg_addr", rf1.reg_addr, 16'h0036);
    chk("rr_busy_after_p", rf1.busy, 0);

    // Address mismatch: no target may respond
    low0 = dut_low_cnt;
    busy0 = busy_cyc;
    bus_start();
    write_byte(8'hA2, ack); chk("mm_dev_ack", ack, 0);
    write_byte(8'h00, ack); chk("mm_byte_ack", ack, 0);
    bus_stop();
    #(4*Q);
    chk("mm_sda_low", dut_low_cnt - low0, 0);
    chk("mm_busy", busy_cyc - busy0, 0);

    // Mid-stream NACK followed by repeated START raises ack_err
    exp_rd1.push_back(16'h0036);
    bus_start();
    write_byte(8'hA1, ack); chk("ae_dev_ack", ack, 1);
    read_byte(rb, 1'b0); chk("ae_byte", rb, 8'h37);
    bus_start();
    bus_stop();
    #(4*Q);
    chk("ae_ack_err", ack_err_cnt, 1);

    // 8-bit pointer wraps 0xFF to 0x00 with upper byte held at zero
    exp_wr1.push_back('{16'h00FF, 8'h01});
    exp_wr1.push_back('{16'h0000, 8'h02});
    bus_start();
    write_byte(8'hA0, ack); chk("w8_dev_ack", ack, 1);
    write_byte(8'hFF, ack);
    write_byte(8'h01, ack);
    write_byte(8'h02, ack); chk("w8_last_ack", ack, 1);
    bus_stop();
    #(4*Q);
    chk("w8_reg_addr", rf1.reg_addr, 16'h0001);

    // 16-bit pointer burst write wrapping 0xFFFF to 0x0000
    exp_wr2.push_back('{16'hFFFF, 8'h11});
    exp_wr2.push_back('{16'h0000, 8'h22});
    bus_start();
    write_byte(8'hA4, ack); chk("w16_dev_ack", ack, 1);
    write_byte(8'hFF, ack); chk("w16_hi_ack", ack, 1);
    write_byte(8'hFF, ack); chk("w16_lo_ack", ack, 1);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); chk("w16_last_ack", ack, 1);
    bus_stop();
    #(4*Q);
    chk("w16_reg_addr", rf2.reg_addr, 16'h0001);

    // STOP after 5 data bits discards the partial byte
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack); chk("sp_sub_ack", ack, 1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    bus_stop();
    #(4*Q);
    chk("sp_busy", rf1.busy, 0);
    chk("sp_reg_addr", rf1.reg_addr, 16'h0040);
    chk("sp_sda", iic_sda, 1);

    // Reset while the target drives a 0 read bit (0x41 has MSB 0)
    exp_rd1.push_back(16'h0040);
    bus_start();
    write_byte(8'hA1, ack); chk("rs_dev_ack", ack, 1);
    chk("rs_msb_driven", iic_sda, 0);
    #7 rst_n = 1'b0;
    #1;
    chk("rs_sda_released", iic_sda, 1);
    chk("rs_reg_addr", rf1.reg_addr, 16'h0000);
    chk("rs_busy", rf1.busy, 0);
    chk("rs_rd_req", rf1.rd_req, 0);
    chk("rs_wr_en", rf1.wr_en, 0);
    #100 rst_n = 1'b1;
    #Q m_scl = 1'b1;
    #(4*Q);
    chk("rs_idle_sda", iic_sda, 1);

    chk("left_wr1", exp_wr1.size(), 0);
    chk("left_wr2", exp_wr2.size(), 0);
    chk("left_rd1", exp_rd1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
